// File: rtl/transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the row and column DCT passes.
// Rows are written in parallel; the block is read out serially in column order.
module transpose_buffer #(
  parameter int unsigned WIDTH = 15
) (
  input  logic                    I_clk,
  input  logic                    I_rst_n,
  input  logic                    I_en,
  input  logic                    I_data_update,
  input  logic signed [WIDTH-1:0] I_f0,
  input  logic signed [WIDTH-1:0] I_f1,
  input  logic signed [WIDTH-1:0] I_f2,
  input  logic signed [WIDTH-1:0] I_f3,
  input  logic signed [WIDTH-1:0] I_f4,
  input  logic signed [WIDTH-1:0] I_f5,
  input  logic signed [WIDTH-1:0] I_f6,
  input  logic signed [WIDTH-1:0] I_f7,
  output logic signed [WIDTH-1:0] O_data,
  output logic                    O_data_valid,
  output logic                    O_block_start,
  output logic                    O_overflow
);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  logic [WIDTH-1:0] mem_q [2][8][8];
  logic [WIDTH-1:0] row_in [8];

  logic             wr_bank_q, wr_bank_d;
  logic [2:0]       wr_row_q, wr_row_d;
  logic [1:0]       full_q, full_d;
  logic             rd_bank_q, rd_bank_d;
  logic [5:0]       rd_cnt_q, rd_cnt_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             bstart_q, bstart_d;
  logic             ovf_q, ovf_d;

  logic             rd_emit;
  logic             rd_last;
  logic             writable;
  logic             mem_we;
  logic [WIDTH-1:0] rd_sample;

  assign row_in[0] = I_f0;
  assign row_in[1] = I_f1;
  assign row_in[2] = I_f2;
  assign row_in[3] = I_f3;
  assign row_in[4] = I_f4;
  assign row_in[5] = I_f5;
  assign row_in[6] = I_f6;
  assign row_in[7] = I_f7;

  // Row index runs fastest so the column DCT sees one full column at a time.
  assign rd_sample = mem_q[rd_bank_q][rd_cnt_q[2:0]][rd_cnt_q[5:3]];

  always_comb begin
    rd_emit = 1'b0;
    unique case (state_q)
      StIdle:  rd_emit = full_q[rd_bank_q];
      StRead:  rd_emit = 1'b1;
      default: rd_emit = 1'b0;
    endcase
    rd_last  = rd_emit && (rd_cnt_q == 6'd63);
    // A full bank frees up in the same cycle its last sample leaves.
    writable = !full_q[wr_bank_q] || (rd_last && (rd_bank_q == wr_bank_q));
    mem_we   = I_en && I_data_update && writable;
  end

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    full_d    = full_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    bstart_d  = bstart_q;
    ovf_d     = ovf_q;

    if (I_en) begin
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
      end
      if (mem_we) begin
        wr_row_d = wr_row_q + 3'd1;
        if (wr_row_q == 3'd7) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end
      ovf_d = I_data_update && !writable;

      valid_d  = rd_emit;
      bstart_d = rd_emit && (rd_cnt_q == 6'd0);
      if (rd_emit) begin
        data_d   = rd_sample;
        rd_cnt_d = rd_cnt_q + 6'd1;
        state_d  = StRead;
        if (rd_last) begin
          rd_bank_d = ~rd_bank_q;
          state_d   = full_q[~rd_bank_q] ? StRead : StIdle;
        end
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_bank_q <= 1'b0;
      wr_row_q  <= 3'd0;
      full_q    <= 2'b00;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= 6'd0;
      state_q   <= StIdle;
      data_q    <= '0;
      valid_q   <= 1'b0;
      bstart_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      bstart_q  <= bstart_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage has no reset; the full flags alone decide what is valid.
  always_ff @(posedge I_clk) begin
    if (mem_we) begin
      for (int c = 0; c < 8; c++) begin
        mem_q[wr_bank_q][wr_row_q][c] <= row_in[c];
      end
    end
  end

  assign O_data        = data_q;
  assign O_data_valid  = valid_q;
  assign O_block_start = bstart_q;
  assign O_overflow    = ovf_q;

endmodule

// File: tb/tb_transpose_buffer.sv
// Directed bench for transpose_buffer: column-order streaming, ping-pong,
// overflow, enable stalls, reset mid-read and extreme values.
module tb_transpose_buffer;
  localparam int unsigned WIDTH = 15;

  logic                    I_clk = 1'b0;
  logic                    I_rst_n;
  logic                    I_en;
  logic                    I_data_update;
  logic signed [WIDTH-1:0] f [8];
  logic signed [WIDTH-1:0] O_data;
  logic                    O_data_valid;
  logic                    O_block_start;
  logic                    O_overflow;

  always #5 I_clk = ~I_clk;

  transpose_buffer #(.WIDTH(WIDTH)) dut (
    .I_clk        (I_clk),
    .I_rst_n      (I_rst_n),
    .I_en         (I_en),
    .I_data_update(I_data_update),
    .I_f0         (f[0]),
    .I_f1         (f[1]),
    .I_f2         (f[2]),
    .I_f3         (f[3]),
    .I_f4         (f[4]),
    .I_f5         (f[5]),
    .I_f6         (f[6]),
    .I_f7         (f[7]),
    .O_data       (O_data),
    .O_data_valid (O_data_valid),
    .O_block_start(O_block_start),
    .O_overflow   (O_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: records samples emitted on enabled edges and checks holds on stalled edges.
  logic en_s = 1'b0;
  int   cyc = 0;
  int   q_val[$];
  int   q_bs[$];
  int   q_cyc[$];
  int   ovf_cnt = 0;
  int   freeze_err = 0;
  logic [WIDTH+2:0] last_out = '0;
  bit   rand_en = 1'b0;

  always @(posedge I_clk) begin
    en_s = I_en;
    cyc++;
  end

  always @(negedge I_clk) begin
    if (I_rst_n) begin
      if (en_s) begin
        if (O_data_valid) begin
          q_val.push_back(int'(O_data));
          q_bs.push_back(int'(O_block_start));
          q_cyc.push_back(cyc);
        end
        if (O_overflow) ovf_cnt++;
      end else if ({O_data, O_data_valid, O_block_start, O_overflow} !== last_out) begin
        freeze_err++;
      end
    end
    last_out = {O_data, O_data_valid, O_block_start, O_overflow};
  end

  function automatic int val(input int mode, input int base, input int r, input int c);
    if (mode == 0) return base + 16 * r + c;
    case ((r + 2 * c) % 3)
      0:       return -16384;
      1:       return 16383;
      default: return -1 - r * c;
    endcase
  endfunction

  task automatic step();
    I_en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(posedge I_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Holds the row until an enabled edge has sampled it.
  task automatic put_row(input int mode, input int base, input int r);
    for (int c = 0; c < 8; c++) f[c] = WIDTH'(val(mode, base, r, c));
    I_data_update = 1'b1;
    for (int t = 0; t < 100; t++) begin
      step();
      if (en_s) break;
    end
    I_data_update = 1'b0;
  endtask

  task automatic clear_mon();
    q_val.delete();
    q_bs.delete();
    q_cyc.delete();
    ovf_cnt    = 0;
    freeze_err = 0;
  endtask

  task automatic do_reset();
    rand_en       = 1'b0;
    I_en          = 1'b1;
    I_data_update = 1'b0;
    I_rst_n       = 1'b0;
    repeat (2) @(posedge I_clk);
    #1;
    I_rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic wait_samples(input string tag, input int n, input int bound);
    for (int t = 0; t < bound; t++) begin
      if (q_val.size() >= n) break;
      step();
    end
    check(tag, int'(q_val.size() >= n), 1);
  endtask

  task automatic check_block(input string tag, input int mode, input int base, input int off);
    int bs_bad;
    bs_bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (q_val.size() > off + k) begin
        check($sformatf("%s_k%0d", tag, k), q_val[off + k], val(mode, base, k % 8, k / 8));
        if (q_bs[off + k] != int'(k == 0)) bs_bad++;
      end
    end
    check({tag, "_bstart"}, bs_bad, 0);
  endtask

  task automatic check_contig(input string tag, input int n);
    int gaps;
    gaps = 0;
    for (int i = 0; i < n; i++) begin
      if (q_cyc.size() > i && q_cyc[i] != q_cyc[0] + i) gaps++;
    end
    check(tag, gaps, 0);
  endtask

  int e_row7;

  initial begin
    I_en          = 1'b1;
    I_data_update = 1'b0;
    for (int c = 0; c < 8; c++) f[c] = '0;
    I_rst_n = 1'b0;
    #2;
    check("rst_data", int'(O_data), 0);
    check("rst_valid", int'(O_data_valid), 0);
    check("rst_bstart", int'(O_block_start), 0);
    check("rst_ovf", int'(O_overflow), 0);

    // Single block, one row every 8 cycles.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      put_row(0, 0, r);
      if (r < 7) idle(7);
    end
    e_row7 = cyc;
    wait_samples("single_wait", 64, 200);
    if (q_cyc.size() > 0) check("single_latency", q_cyc[0], e_row7 + 1);
    check_block("single", 0, 0, 0);
    check_contig("single_contig", 64);
    idle(3);
    check("single_valid_drop", int'(O_data_valid), 0);
    check("single_count", q_val.size(), 64);

    // Back-to-back blocks: B = A + 1000 continues A's row cadence.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      put_row(0, 0, r);
      idle(7);
    end
    for (int r = 0; r < 8; r++) begin
      put_row(0, 1000, r);
      if (r < 7) idle(7);
    end
    wait_samples("b2b_wait", 128, 300);
    check_block("b2b_a", 0, 0, 0);
    check_block("b2b_b", 0, 1000, 64);
    check_contig("b2b_contig", 128);

    // Overflow: 24 consecutive rows. Bank 1 fills at row 15 while bank 0 is
    // still draining (its sample 63 is ~55 cycles later), so rows 16..23 drop.
    do_reset();
    for (int r = 0; r < 24; r++) put_row(0, 0, r);
    wait_samples("ovf_wait", 128, 300);
    check_block("ovf_b0", 0, 0, 0);
    check_block("ovf_b1", 0, 128, 64);
    check_contig("ovf_contig", 128);
    check("ovf_count", ovf_cnt, 8);
    idle(10);
    check("ovf_no_extra", q_val.size(), 128);

    // Enable stall: pseudo-random I_en throughout.
    do_reset();
    rand_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      put_row(0, 0, r);
      if (r < 7) idle(7);
    end
    wait_samples("stall_wait", 64, 600);
    rand_en = 1'b0;
    idle(5);
    check("stall_count", q_val.size(), 64);
    check_block("stall", 0, 0, 0);
    check("stall_freeze", freeze_err, 0);

    // Reset mid-read at sample 20, with a partial block pending in bank 1.
    do_reset();
    for (int r = 0; r < 8; r++) put_row(0, 3000, r);
    for (int r = 0; r < 3; r++) put_row(0, 4000, r);
    for (int t = 0; t < 200; t++) begin
      if (q_val.size() >= 20) break;
      step();
    end
    check("mid_pre_valid", int'(O_data_valid), 1);
    check("mid_pre_data", int'(O_data), val(0, 3000, 20 % 8, 20 / 8));
    I_rst_n = 1'b0;
    #1;
    check("mid_rst_data", int'(O_data), 0);
    check("mid_rst_valid", int'(O_data_valid), 0);
    check("mid_rst_bstart", int'(O_block_start), 0);
    check("mid_rst_ovf", int'(O_overflow), 0);
    @(posedge I_clk);
    #1;
    I_rst_n = 1'b1;
    clear_mon();
    for (int r = 0; r < 8; r++) put_row(0, 0, r);
    e_row7 = cyc;
    wait_samples("mid_wait", 64, 200);
    if (q_cyc.size() > 0) check("mid_latency", q_cyc[0], e_row7 + 1);
    check_block("mid_fresh", 0, 0, 0);
    idle(5);
    check("mid_count", q_val.size(), 64);

    // Extreme values, bit-exact through the transpose.
    do_reset();
    for (int r = 0; r < 8; r++) put_row(1, 0, r);
    wait_samples("ext_wait", 64, 200);
    check_block("ext", 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
